// File: rtl/riscv_fetch_pkg.sv
// Shared constants and helpers for the Riscv150 decoupled fetch front end.
package riscv_fetch_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   function automatic bit params_ok(input int unsigned pc_width,
                                    input int unsigned reset_pc,
                                    input int unsigned mem_latency,
                                    input int unsigned fq_depth);
      bit ok;
      ok = (pc_width >= 3) && (pc_width <= 32);
      ok = ok && ((reset_pc % 4) == 0) && ((reset_pc >> pc_width) == 0);
      ok = ok && (mem_latency >= 1) && (mem_latency <= 3);
      ok = ok && (fq_depth >= 2) && ((fq_depth & (fq_depth - 1)) == 0);
      ok = ok && (fq_depth >= mem_latency + 1);
      return ok;
   endfunction

endpackage

// File: rtl/riscv_fetch_unit_fetch_queue.sv
// Synchronous FIFO of {instruction, pc} pairs with flush; head is read from registered storage.
module fetch_queue #(
   parameter int unsigned PC_WIDTH = 14,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr,
   input  logic [31:0]              wr_inst,
   input  logic [PC_WIDTH-1:0]      wr_pc,
   input  logic                     rd,
   output logic [31:0]              rd_inst,
   output logic [PC_WIDTH-1:0]      rd_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]         mem_inst [DEPTH];
   logic [PC_WIDTH-1:0] mem_pc   [DEPTH];
   logic [AW-1:0]       wptr;
   logic [AW-1:0]       rptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (rd) rptr <= rptr + AW'(1);
         count <= count + CW'(wr) - CW'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_inst[wptr] <= wr_inst;
         mem_pc[wptr]   <= wr_pc;
      end
   end

   assign rd_inst = mem_inst[rptr];
   assign rd_pc   = mem_pc[rptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled fetch front end: PC generator, MEM_LATENCY-deep in-flight tracker and fetch queue.
module riscv_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 14,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned FQ_DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic [31:0]         icache_addr,
   output logic                icache_re,
   input  logic [31:0]         instruction,
   output logic [31:0]         inst_out,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                inst_valid,
   input  logic                inst_ready
);

   localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

   if (!params_ok(PC_WIDTH, RESET_PC, MEM_LATENCY, FQ_DEPTH)) begin : g_bad_params
      $error("riscv_fetch_unit: illegal parameter combination");
   end

   logic [PC_WIDTH-1:0]    pc_q;
   logic [MEM_LATENCY-1:0] slot_v;
   logic [PC_WIDTH-1:0]    slot_pc [MEM_LATENCY];

   logic [CW-1:0]          fq_count;
   logic                   fq_full, fq_empty;
   logic                   fq_wr, fq_rd, fq_flush;
   logic [31:0]            q_inst;
   logic [PC_WIDTH-1:0]    q_pc;
   logic                   deq, issue;
   int unsigned            occupancy;

   always_comb begin
      occupancy = 32'(fq_count);
      for (int unsigned i = 0; i < MEM_LATENCY; i++) occupancy += 32'(slot_v[i]);
   end

   // Occupancy bound counts reads already in flight, so the queue can never overflow.
   assign deq      = inst_valid && inst_ready && !stall;
   assign issue    = !stall && !redirect && !rst && ((occupancy - 32'(deq)) < FQ_DEPTH);
   assign fq_wr    = !stall && !redirect && slot_v[MEM_LATENCY-1];
   assign fq_rd    = deq;
   assign fq_flush = !stall && redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= PC_WIDTH'(RESET_PC);
         slot_v <= '0;
      end else if (!stall) begin
         if (redirect) begin
            pc_q   <= PC_WIDTH'(align_pc(32'(redirect_pc)));
            slot_v <= '0;
         end else begin
            if (issue) pc_q <= pc_q + PC_WIDTH'(4);
            slot_v[0]  <= issue;
            slot_pc[0] <= pc_q;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
               slot_v[i]  <= slot_v[i-1];
               slot_pc[i] <= slot_pc[i-1];
            end
         end
      end
   end

   fetch_queue #(
      .PC_WIDTH (PC_WIDTH),
      .DEPTH    (FQ_DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .flush   (fq_flush),
      .wr      (fq_wr),
      .wr_inst (instruction),
      .wr_pc   (slot_pc[MEM_LATENCY-1]),
      .rd      (fq_rd),
      .rd_inst (q_inst),
      .rd_pc   (q_pc),
      .count   (fq_count),
      .full    (fq_full),
      .empty   (fq_empty)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fq_wr && fq_full && !fq_rd));

   assign icache_addr = 32'(pc_q);
   assign icache_re   = issue;
   assign inst_valid  = !fq_empty;
   assign inst_out    = fq_empty ? NOP : q_inst;
   assign pc_out      = fq_empty ? '0 : q_pc;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: three configurations exercised one after another.
module tb_riscv_fetch_unit;
   import riscv_fetch_pkg::*;

   typedef struct {
      int          dut;
      int          cyc;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t iss_q[$];
   exp_t out_q[$];
   int   total = 0;
   int   bad   = 0;
   logic done  = 1'b0;

   bit          rst_prev   [3];
   bit          stall_prev [3];
   logic [31:0] last_addr  [3];
   logic [31:0] last_pc    [3];
   logic [31:0] last_out   [3];
   logic        last_valid [3];

   // A: defaults (ML=1, depth 4); B: ML=2, depth 8; C: 6-bit PC starting at 0x38
   logic        a_rst, a_stall, a_redir, a_ready, a_re, a_valid;
   logic [13:0] a_rpc, a_pc;
   logic [31:0] a_addr, a_inst, a_out, a_pipe;
   logic        b_rst, b_stall, b_redir, b_ready, b_re, b_valid;
   logic [13:0] b_rpc, b_pc;
   logic [31:0] b_addr, b_inst, b_out, b_pipe0, b_pipe1;
   logic        c_rst, c_stall, c_redir, c_ready, c_re, c_valid;
   logic [5:0]  c_rpc, c_pc;
   logic [31:0] c_addr, c_inst, c_out, c_pipe;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Instruction memory: fixed latency, frozen by the same stall as the fetch unit
   always @(posedge clk) if (!a_stall) a_pipe <= a_addr;
   always @(posedge clk) if (!b_stall) begin b_pipe0 <= b_addr; b_pipe1 <= b_pipe0; end
   always @(posedge clk) if (!c_stall) c_pipe <= c_addr;
   assign a_inst = word(a_pipe);
   assign b_inst = word(b_pipe1);
   assign c_inst = word(c_pipe);

   riscv_fetch_unit u_a (
      .clk(clk), .rst(a_rst), .stall(a_stall), .redirect(a_redir), .redirect_pc(a_rpc),
      .icache_addr(a_addr), .icache_re(a_re), .instruction(a_inst),
      .inst_out(a_out), .pc_out(a_pc), .inst_valid(a_valid), .inst_ready(a_ready)
   );

   riscv_fetch_unit #(.PC_WIDTH(14), .RESET_PC(0), .MEM_LATENCY(2), .FQ_DEPTH(8)) u_b (
      .clk(clk), .rst(b_rst), .stall(b_stall), .redirect(b_redir), .redirect_pc(b_rpc),
      .icache_addr(b_addr), .icache_re(b_re), .instruction(b_inst),
      .inst_out(b_out), .pc_out(b_pc), .inst_valid(b_valid), .inst_ready(b_ready)
   );

   riscv_fetch_unit #(.PC_WIDTH(6), .RESET_PC(32'h38), .MEM_LATENCY(1), .FQ_DEPTH(4)) u_c (
      .clk(clk), .rst(c_rst), .stall(c_stall), .redirect(c_redir), .redirect_pc(c_rpc),
      .icache_addr(c_addr), .icache_re(c_re), .instruction(c_inst),
      .inst_out(c_out), .pc_out(c_pc), .inst_valid(c_valid), .inst_ready(c_ready)
   );

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut=%0d cycle=%0d: got %h, want %h", name, d, cyc, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic [31:0] rst_pc, input logic rst, input logic re,
                      input logic [31:0] addr, input logic valid, input logic ready,
                      input logic stall, input logic [31:0] pc, input logic [31:0] out);
      exp_t e;
      if (rst) begin
         if (rst_prev[d]) begin
            chk("rst_re", d, 32'(re), 32'd0);
            chk("rst_addr", d, addr, rst_pc);
            chk("rst_valid", d, 32'(valid), 32'd0);
         end
      end else begin
         if (re) begin
            if (iss_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_issue dut=%0d cycle=%0d: got addr %h, want no issue", d, cyc, addr);
            end else begin
               e = iss_q.pop_front();
               chk("issue_dut", d, 32'(d), 32'(e.dut));
               chk("issue_cycle", d, 32'(cyc), 32'(e.cyc));
               chk("issue_addr", d, addr, e.val);
            end
         end
         if (valid && ready && !stall) begin
            if (out_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_dequeue dut=%0d cycle=%0d: got pc %h, want no output", d, cyc, pc);
            end else begin
               e = out_q.pop_front();
               chk("deq_dut", d, 32'(d), 32'(e.dut));
               chk("deq_cycle", d, 32'(cyc), 32'(e.cyc));
               chk("pc_out", d, pc, e.val);
               chk("inst_out", d, out, word(e.val));
            end
         end
         if (stall_prev[d]) begin
            chk("frozen_addr", d, addr, last_addr[d]);
            chk("frozen_valid", d, 32'(valid), 32'(last_valid[d]));
            chk("frozen_pc", d, pc, last_pc[d]);
            chk("frozen_inst", d, out, last_out[d]);
         end
      end
      if (valid == 1'b0) begin
         chk("empty_inst", d, out, NOP);
         chk("empty_pc", d, pc, 32'd0);
      end
      rst_prev[d]   = rst;
      stall_prev[d] = stall;
      last_addr[d]  = addr;
      last_pc[d]    = pc;
      last_out[d]   = out;
      last_valid[d] = valid;
   endtask

   always @(negedge clk) begin
      mon(0, 32'h00, a_rst, a_re, a_addr, a_valid, a_ready, a_stall, 32'(a_pc), a_out);
      mon(1, 32'h00, b_rst, b_re, b_addr, b_valid, b_ready, b_stall, 32'(b_pc), b_out);
      mon(2, 32'h38, c_rst, c_re, c_addr, c_valid, c_ready, c_stall, 32'(c_pc), c_out);
      if (done) begin
         chk("issues_outstanding", -1, 32'(iss_q.size()), 32'd0);
         chk("outputs_outstanding", -1, 32'(out_q.size()), 32'd0);
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic void push_iss(input int d, input int c, input logic [31:0] a);
      iss_q.push_back('{d, c, a});
   endfunction

   function automatic void push_out(input int d, input int c, input logic [31:0] p);
      out_q.push_back('{d, c, p});
   endfunction

   initial begin
      int base;
      a_rst = 1; a_stall = 0; a_redir = 0; a_ready = 0; a_rpc = '0;
      b_rst = 1; b_stall = 0; b_redir = 0; b_ready = 0; b_rpc = '0;
      c_rst = 1; c_stall = 0; c_redir = 0; c_ready = 0; c_rpc = '0;
      tick(3);

      // A: streaming from reset, one fetch per cycle, first valid two cycles after first issue
      a_ready = 1; a_rst = 0; base = cyc;
      for (int k = 0; k < 6; k++) push_iss(0, base + k, 32'(4 * k));
      for (int k = 0; k < 4; k++) push_out(0, base + 2 + k, 32'(4 * k));
      tick(6); a_rst = 1; a_ready = 0;
      tick(2);

      // A: back-pressure fills to depth, resume, 5-cycle stall, then redirect with response and dequeue
      a_rst = 0; base = cyc;
      for (int k = 0; k < 16; k++)
         push_iss(0, base + (k < 4 ? k : (k < 12 ? k + 3 : k + 8)), 32'(4 * k));
      for (int k = 0; k < 13; k++)
         push_out(0, base + (k < 8 ? k + 7 : k + 12), 32'(4 * k));
      tick(7); a_ready = 1;
      tick(8); a_stall = 1;
      tick(5); a_stall = 0;
      tick(4); a_redir = 1; a_rpc = 14'h0206;
      for (int m = 0; m < 6; m++) push_iss(0, base + 25 + m, 32'h204 + 32'(4 * m));
      for (int m = 0; m < 4; m++) push_out(0, base + 27 + m, 32'h204 + 32'(4 * m));
      tick(1); a_redir = 0;
      tick(6); a_rst = 1; a_ready = 0;
      tick(2);

      // B: redirect to 0x0123 with 2 reads in flight and 3 queued
      b_rst = 0; base = cyc;
      for (int k = 0; k < 5; k++) push_iss(1, base + k, 32'(4 * k));
      for (int m = 0; m < 7; m++) push_iss(1, base + 6 + m, 32'h120 + 32'(4 * m));
      for (int m = 0; m < 4; m++) push_out(1, base + 9 + m, 32'h120 + 32'(4 * m));
      tick(5); b_redir = 1; b_rpc = 14'h0123;
      tick(1); b_redir = 0; b_ready = 1;
      tick(7); b_rst = 1; b_ready = 0;
      tick(2);

      // C: 6-bit PC wraps from 0x3C to 0x00
      c_ready = 1; c_rst = 0; base = cyc;
      for (int m = 0; m < 6; m++) push_iss(2, base + m, (32'h38 + 32'(4 * m)) & 32'h3F);
      for (int m = 0; m < 4; m++) push_out(2, base + 2 + m, (32'h38 + 32'(4 * m)) & 32'h3F);
      tick(6); c_rst = 1; c_ready = 0;
      tick(2);
      done = 1'b1;
   end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Parametrised, decoupled instruction-fetch front end for the Riscv150 pipeline. It replaces the single PC register with:
- a PC generator that issues reads to the instruction cache,
- in-flight tracking for a configurable memory read latency,
- a fetch queue that hands instructions to decode over a valid/ready handshake.

Branch and jump redirects from execute squash all in-flight and queued fetches.

## Interface
Parameters:
- PC_WIDTH, 14, byte-address width of PC (instruction space 2^PC_WIDTH bytes)
- RESET_PC, 0, PC issued first after reset (low 2 bits must be 0)
- MEM_LATENCY, 1, cycles from icache_re to valid instruction (1..3)
- FQ_DEPTH, 4, fetch-queue entries (power of 2, ≥ MEM_LATENCY+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  global freeze (same signal as the memory system stall)
- redirect  in  1  one-cycle request to restart fetch at redirect_pc
- redirect_pc  in  PC_WIDTH  new fetch target
- icache_addr  out  32  zero-extended fetch PC
- icache_re  out  1  read issue strobe
- instruction  in  32  instruction cache read data
- inst_out  out  32  queue head instruction (NOP 32'h00000013 when empty)
- pc_out  out  PC_WIDTH  PC of inst_out (0 when empty)
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head this cycle

## Operation
- Reset values: PC=RESET_PC, queue empty, in-flight slots cleared.
  - Outputs: icache_re=0, icache_addr=RESET_PC, inst_valid=0, inst_out=NOP, pc_out=0.
- Occupancy count = queue entries + in-flight reads.
- Issue rule: icache_re=1 when stall=0, redirect=0, rst=0, and (count − dequeue_this_cycle) < FQ_DEPTH.
- On issue, PC <= PC+4 modulo 2^PC_WIDTH. At 2^PC_WIDTH−4 the next PC wraps to 0.
- In-flight tracker: MEM_LATENCY-deep shift register of {valid, pc}.
  - The slot leaving the last stage writes {instruction, pc} into the queue.
- Dequeue when inst_valid && inst_ready. The head advances on that edge.
- Redirect (stall=0):
  - Queue flushed, all in-flight valid bits cleared.
  - PC <= {redirect_pc[PC_WIDTH-1:2], 2'b00}. No issue in the redirect cycle.
  - A response arriving in the same cycle is discarded.
  - A same-cycle dequeue counts as completed.
- Stall=1:
  - No register changes and icache_re=0.
  - Redirect and inst_ready are ignored; the issuer must hold redirect until stall drops.
  - In-flight slots freeze. The memory system obeys the same stall, so responses keep their alignment.
- Priority: rst > stall > redirect > issue/dequeue.
- Full: no issue. Empty: inst_valid=0, inst_out=NOP.

## Timing
- icache_re in cycle t → instruction sampled at the end of cycle t+MEM_LATENCY → inst_valid in cycle t+MEM_LATENCY+1 (unstalled cycles).
- First issue: the cycle after rst is deasserted.
- Redirect in cycle r: first new issue in cycle r+1, with icache_addr=redirect_pc. First new inst_valid in cycle r+1+MEM_LATENCY+1.
- Sustained throughput: 1 instruction/cycle while inst_ready=1 (guaranteed by FQ_DEPTH ≥ MEM_LATENCY+1).
- inst_out, pc_out, inst_valid are driven from registered queue state only (no combinational path from instruction).
- icache_re depends combinationally on stall, redirect and inst_ready.

## Structure
- Package riscv_fetch_pkg holds:
  - the NOP constant 32'h00000013
  - the PC alignment function
  - the parameter legality checks
- Sub-module fetch_queue: synchronous FIFO {32-bit inst, PC_WIDTH pc}, width/depth parametrised, with a flush input.
  - Provides count, full and empty.
  - Read and write pointers wrap modulo FQ_DEPTH.
- The top module holds the PC register, the in-flight shift register, the issue logic and the count.

## Test plan
- Reset, MEM_LATENCY=1, inst_ready=1 → icache_addr 0,4,8,… one per cycle; inst_valid from cycle 3 with pc_out 0,4,8.
- inst_ready=0, FQ_DEPTH=4 → exactly 4 issues then icache_re=0. Raise inst_ready → one dequeue and one issue per cycle, no lost or duplicated PCs.
- MEM_LATENCY=2, redirect to 0x0123 with 2 reads in flight and 3 queued →
  - next icache_addr=0x0120
  - stale PCs never appear on pc_out
  - first valid pc_out=0x0120
- stall held 5 cycles mid-stream → all outputs frozen and icache_re=0. Stream resumes with no gaps or repeats.
- redirect together with a response arrival and a dequeue → the response is dropped, the dequeued instruction is consumed, and the queue is empty in the next cycle.
- PC_WIDTH=6, run from RESET_PC=0x38 → icache_addr 0x38, 0x3C, 0x00, 0x04.
